multdiv_ctrl: RTL



---
 rtl/multdiv_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/multdiv_ctrl.sv
// Control sequencer for the shared iterative multiply/divide datapath.
// Owns the iteration counter; datapath strobes are decoded from the registered state.
module multdiv_ctrl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   input  logic             divisor_zero,
   input  logic             sign_a,
   input  logic             sign_b,
   output logic             dp_load,
   output logic             dp_step,
   output logic             dp_is_div,
   output logic             dp_negate,
   output logic [CNT_W-1:0] count,
   output logic             busy,
   output logic             data_resultRDY,
   output logic             data_exception
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      ITER = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } state_e;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

   state_e           state_q;
   logic [CNT_W-1:0] count_q;
   logic             is_div_q;
   logic             neg_q;
   logic             exc_q;
   logic             start_s;
   logic             div_start_s;

   // ctrl_MULT wins when both start pulses arrive together
   assign start_s     = ctrl_MULT | ctrl_DIV;
   assign div_start_s = ctrl_DIV & ~ctrl_MULT;

   // State, counter and per-operation flags; a start restarts from any state
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         count_q  <= '0;
         is_div_q <= 1'b0;
         neg_q    <= 1'b0;
         exc_q    <= 1'b0;
      end else if (start_s) begin
         count_q  <= '0;
         is_div_q <= div_start_s;
         neg_q    <= sign_a ^ sign_b;
         if (div_start_s && divisor_zero) begin
            state_q <= DONE;
            exc_q   <= 1'b1;
         end else begin
            state_q <= LOAD;
            exc_q   <= 1'b0;
         end
      end else begin
         case (state_q)
            IDLE: begin
               state_q <= IDLE;
               count_q <= '0;
            end
            LOAD: begin
               state_q <= ITER;
               count_q <= '0;
            end
            ITER: begin
               if (count_q == CNT_LAST) begin
                  state_q <= FIX;
                  count_q <= CNT_FULL;
               end else begin
                  count_q <= count_q + CNT_W'(1);
               end
            end
            FIX: begin
               state_q <= DONE;
            end
            DONE: begin
               state_q <= IDLE;
               count_q <= '0;
            end
            default: begin
               state_q <= IDLE;
               count_q <= '0;
            end
         endcase
      end
   end

   // Strobe decode: load, step and negate are mutually exclusive by state
   always_comb begin
      dp_load        = 1'b0;
      dp_step        = 1'b0;
      dp_negate      = 1'b0;
      busy           = 1'b0;
      data_resultRDY = 1'b0;
      data_exception = 1'b0;
      case (state_q)
         LOAD: begin
            dp_load = 1'b1;
            busy    = 1'b1;
         end
         ITER: begin
            dp_step = 1'b1;
            busy    = 1'b1;
         end
         FIX: begin
            dp_negate = neg_q;
            busy      = 1'b1;
         end
         DONE: begin
            data_resultRDY = 1'b1;
            data_exception = exc_q;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   assign count     = count_q;
   assign dp_is_div = is_div_q;

endmodule
